// File: rtl/traffic_phase_controller_if.sv
// Display-side bundle driven by the phase controller into the LCD output stage.
// master = phase controller, slave = LCD stage.
interface traffic_phase_controller_if;
  logic [2:0] Principal_Road;
  logic [2:0] Secondary_Road;
  logic [1:0] Principal_Pedestrian;
  logic [1:0] Secondary_Pedestrian;
  logic [6:0] timeRemaining;
  logic [1:0] StateFlag;
  logic [1:0] PhraseSel;

  modport master (
    output Principal_Road, Secondary_Road, Principal_Pedestrian, Secondary_Pedestrian,
    output timeRemaining, StateFlag, PhraseSel
  );

  modport slave (
    input Principal_Road, Secondary_Road, Principal_Pedestrian, Secondary_Pedestrian,
    input timeRemaining, StateFlag, PhraseSel
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// Two-road traffic phase sequencer with 1 s tick, countdown and flashing-amber fault mode.
// Optional all-red clearance after each amber phase: define ALL_RED_CLEARANCE_EN.
module traffic_phase_controller #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                              clock50MHz,
  input  logic                              reset,
  input  logic [6:0]                        Tpv,
  input  logic [6:0]                        Tsv,
  input  logic [6:0]                        Ta,
  traffic_phase_controller_if.master        o_lcd
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] LampRed   = 3'b100;
  localparam logic [2:0] LampAmber = 3'b010;
  localparam logic [2:0] LampGreen = 3'b001;
  localparam logic [1:0] PedStop   = 2'b10;
  localparam logic [1:0] PedWalk   = 2'b01;

  typedef enum logic [2:0] {StInit, StPg, StPy, StSg, StSy, StFault, StAr} state_e;

  state_e          r_state,    w_state_d;
  logic [CntW-1:0] r_tick_cnt, w_tick_cnt_d;
  logic [6:0]      r_time,     w_time_d;
  logic [2:0]      r_p_road,   w_p_road_d;
  logic [2:0]      r_s_road,   w_s_road_d;
  logic [1:0]      r_p_ped,    w_p_ped_d;
  logic [1:0]      r_s_ped,    w_s_ped_d;
  logic [1:0]      r_flag,     w_flag_d;
  logic [1:0]      r_phrase,   w_phrase_d;

  logic   w_tick, w_all_valid, w_load;
  state_e w_load_tgt;

  assign w_tick      = (r_tick_cnt == CntW'(TICK_DIV - 1));
  assign w_all_valid = (Tpv != 7'd0) && (Tpv <= 7'd99) &&
                       (Tsv != 7'd0) && (Tsv <= 7'd99) &&
                       (Ta  != 7'd0) && (Ta  <= 7'd99);

  always_comb begin
    w_state_d    = r_state;
    w_tick_cnt_d = w_tick ? '0 : r_tick_cnt + 1'b1;
    w_time_d     = r_time;
    w_p_road_d   = r_p_road;
    w_s_road_d   = r_s_road;
    w_p_ped_d    = r_p_ped;
    w_s_ped_d    = r_s_ped;
    w_flag_d     = r_flag;
    w_phrase_d   = r_phrase;
    w_load       = 1'b0;
    w_load_tgt   = StPg;

    case (r_state)
      StInit: begin
        w_load     = 1'b1;
        w_load_tgt = StPg;
      end
      StPg, StPy, StSg, StSy: begin
        if (w_tick) begin
          if (r_time > 7'd1) begin
            w_time_d = r_time - 7'd1;
          end else begin
            w_load = 1'b1;
            case (r_state)
              StPg:    w_load_tgt = StPy;
`ifdef ALL_RED_CLEARANCE_EN
              StPy:    w_load_tgt = StAr;
              StSg:    w_load_tgt = StSy;
              default: w_load_tgt = StAr;
`else
              StPy:    w_load_tgt = StSg;
              StSg:    w_load_tgt = StSy;
              default: w_load_tgt = StPg;
`endif
            endcase
          end
        end
      end
`ifdef ALL_RED_CLEARANCE_EN
      StAr: begin
        // StateFlag still carries the amber phase we came from.
        if (w_tick) begin
          w_load     = 1'b1;
          w_load_tgt = (r_flag == 2'd1) ? StSg : StPg;
        end
      end
`endif
      StFault: begin
        if (w_tick) begin
          if (w_all_valid) begin
            w_load     = 1'b1;
            w_load_tgt = StPg;
          end else begin
            w_p_road_d = r_p_road ^ LampAmber;
            w_s_road_d = r_s_road ^ LampAmber;
          end
        end
      end
      default: w_state_d = StInit;
    endcase

    if (w_load) begin
      w_tick_cnt_d = '0;
      w_p_ped_d    = PedStop;
      w_s_ped_d    = PedStop;
      if (w_load_tgt == StAr) begin
        // Clearance is entered unconditionally; validity is checked on the way out.
        w_state_d  = StAr;
        w_time_d   = 7'd1;
        w_p_road_d = LampRed;
        w_s_road_d = LampRed;
        w_phrase_d = 2'd2;
      end else if (!w_all_valid) begin
        w_state_d  = StFault;
        w_time_d   = 7'd0;
        w_p_road_d = LampAmber;
        w_s_road_d = LampAmber;
        w_flag_d   = 2'd0;
        w_phrase_d = 2'd3;
      end else begin
        w_state_d = w_load_tgt;
        case (w_load_tgt)
          StPg: begin
            w_time_d   = Tpv;
            w_p_road_d = LampGreen;
            w_s_road_d = LampRed;
            w_s_ped_d  = PedWalk;
            w_flag_d   = 2'd0;
            w_phrase_d = 2'd0;
          end
          StPy: begin
            w_time_d   = Ta;
            w_p_road_d = LampAmber;
            w_s_road_d = LampRed;
            w_flag_d   = 2'd1;
            w_phrase_d = 2'd0;
          end
          StSg: begin
            w_time_d   = Tsv;
            w_p_road_d = LampRed;
            w_s_road_d = LampGreen;
            w_p_ped_d  = PedWalk;
            w_flag_d   = 2'd2;
            w_phrase_d = 2'd1;
          end
          default: begin
            w_time_d   = Ta;
            w_p_road_d = LampRed;
            w_s_road_d = LampAmber;
            w_flag_d   = 2'd3;
            w_phrase_d = 2'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      r_state    <= StInit;
      r_tick_cnt <= '0;
      r_time     <= 7'd0;
      r_p_road   <= LampRed;
      r_s_road   <= LampRed;
      r_p_ped    <= PedStop;
      r_s_ped    <= PedStop;
      r_flag     <= 2'd0;
      r_phrase   <= 2'd0;
    end else begin
      r_state    <= w_state_d;
      r_tick_cnt <= w_tick_cnt_d;
      r_time     <= w_time_d;
      r_p_road   <= w_p_road_d;
      r_s_road   <= w_s_road_d;
      r_p_ped    <= w_p_ped_d;
      r_s_ped    <= w_s_ped_d;
      r_flag     <= w_flag_d;
      r_phrase   <= w_phrase_d;
    end
  end

  assign o_lcd.Principal_Road       = r_p_road;
  assign o_lcd.Secondary_Road       = r_s_road;
  assign o_lcd.Principal_Pedestrian = r_p_ped;
  assign o_lcd.Secondary_Pedestrian = r_s_ped;
  assign o_lcd.timeRemaining        = r_time;
  assign o_lcd.StateFlag            = r_flag;
  assign o_lcd.PhraseSel            = r_phrase;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed scoreboard bench for traffic_phase_controller (TICK_DIV = 4).
// Covers AR clearance when ALL_RED_CLEARANCE_EN is defined.
module tb_traffic_phase_controller;

  localparam int unsigned TickDiv = 4;

  localparam int PhPg    = 0;
  localparam int PhPy    = 1;
  localparam int PhSg    = 2;
  localparam int PhSy    = 3;
  localparam int PhRst   = 4;
  localparam int PhFltOn = 5;
  localparam int PhFltOf = 6;
  localparam int PhArP   = 7;
  localparam int PhArS   = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] tpv, tsv, ta;

  traffic_phase_controller_if u_if ();

  traffic_phase_controller #(.TICK_DIV(TickDiv)) u_dut (
    .clock50MHz (clk),
    .reset      (rst_n),
    .Tpv        (tpv),
    .Tsv        (tsv),
    .Ta         (ta),
    .o_lcd      (u_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Packing: {P road, S road, P ped, S ped, timeRemaining, StateFlag, PhraseSel}
  function automatic logic [20:0] pack_exp(int ph, logic [6:0] tr);
    logic [2:0] pr, sr;
    logic [1:0] pp, sp, sf, ps;
    case (ph)
      PhPg:    begin pr = 3'b001; sr = 3'b100; pp = 2'b10; sp = 2'b01; sf = 2'd0; ps = 2'd0; end
      PhPy:    begin pr = 3'b010; sr = 3'b100; pp = 2'b10; sp = 2'b10; sf = 2'd1; ps = 2'd0; end
      PhSg:    begin pr = 3'b100; sr = 3'b001; pp = 2'b01; sp = 2'b10; sf = 2'd2; ps = 2'd1; end
      PhSy:    begin pr = 3'b100; sr = 3'b010; pp = 2'b10; sp = 2'b10; sf = 2'd3; ps = 2'd1; end
      PhFltOn: begin pr = 3'b010; sr = 3'b010; pp = 2'b10; sp = 2'b10; sf = 2'd0; ps = 2'd3; end
      PhFltOf: begin pr = 3'b000; sr = 3'b000; pp = 2'b10; sp = 2'b10; sf = 2'd0; ps = 2'd3; end
      PhArP:   begin pr = 3'b100; sr = 3'b100; pp = 2'b10; sp = 2'b10; sf = 2'd1; ps = 2'd2; end
      PhArS:   begin pr = 3'b100; sr = 3'b100; pp = 2'b10; sp = 2'b10; sf = 2'd3; ps = 2'd2; end
      default: begin pr = 3'b100; sr = 3'b100; pp = 2'b10; sp = 2'b10; sf = 2'd0; ps = 2'd0; end
    endcase
    return {pr, sr, pp, sp, tr, sf, ps};
  endfunction

  function automatic logic [20:0] observe();
    return {u_if.Principal_Road, u_if.Secondary_Road, u_if.Principal_Pedestrian,
            u_if.Secondary_Pedestrian, u_if.timeRemaining, u_if.StateFlag, u_if.PhraseSel};
  endfunction

  task automatic push(input string tag, input int ph, input logic [6:0] tr);
    exp_t e;
    e.tag = tag;
    e.v   = pack_exp(ph, tr);
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [20:0] obs;
    e   = sb.pop_front();
    obs = observe();
    n_chk++;
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
  endtask

  task automatic expect_cycles(input string tag, input int ph, input logic [6:0] tr,
                               input int n);
    for (int i = 0; i < n; i++) begin
      push(tag, ph, tr);
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic run_phase(input string tag, input int ph, input int hi, input int lo);
    for (int s = hi; s >= lo; s--) expect_cycles(tag, ph, 7'(s), TickDiv);
  endtask

  task automatic apply_reset(input logic [6:0] p, input logic [6:0] s, input logic [6:0] a);
    @(negedge clk);
    rst_n = 1'b0;
    tpv   = p;
    tsv   = s;
    ta    = a;
    @(negedge clk);
    push("reset_hold", PhRst, 7'd0);
    check_now();
    rst_n = 1'b1;
  endtask

  initial begin
    tpv = 7'd3;
    tsv = 7'd2;
    ta  = 7'd1;
    #2 rst_n = 1'b0;
    #1;
    push("reset_state", PhRst, 7'd0);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic cycle
    run_phase("pg_first", PhPg, 3, 1);
    run_phase("py_first", PhPy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_after_py", PhArP, 1, 1);
`endif
    run_phase("sg_first", PhSg, 2, 1);
    run_phase("sy_first", PhSy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_after_sy", PhArS, 1, 1);
`endif
    run_phase("pg_again", PhPg, 3, 3);

    // Tpv change mid-PG only affects the next PG
    tpv = 7'd5;
    run_phase("pg_running_old", PhPg, 2, 1);
    run_phase("py_second", PhPy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_after_py2", PhArP, 1, 1);
`endif
    run_phase("sg_second", PhSg, 2, 1);
    run_phase("sy_second", PhSy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_after_sy2", PhArS, 1, 1);
`endif
    run_phase("pg_new_tpv", PhPg, 5, 1);
    run_phase("py_third", PhPy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_after_py3", PhArP, 1, 1);
`endif
    expect_cycles("sg_before_reset", PhSg, 7'd2, 2);

    // Asynchronous reset mid-SG, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    push("reset_async", PhRst, 7'd0);
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    run_phase("pg_after_reset", PhPg, 5, 5);

    // Invalid amber duration at reset release -> flashing fault
    apply_reset(7'd5, 7'd2, 7'd0);
    expect_cycles("fault_lit", PhFltOn, 7'd0, TickDiv);
    expect_cycles("fault_off", PhFltOf, 7'd0, TickDiv);
    expect_cycles("fault_lit2", PhFltOn, 7'd0, TickDiv);
    ta = 7'd2;
    run_phase("pg_fault_exit", PhPg, 5, 1);
    run_phase("py_ta2", PhPy, 2, 2);

    // Tsv out of range when PY expires -> fault instead of SG
    tsv = 7'd100;
    run_phase("py_ta2_end", PhPy, 1, 1);
`ifdef ALL_RED_CLEARANCE_EN
    run_phase("ar_before_fault", PhArP, 1, 1);
`endif
    expect_cycles("fault_tsv", PhFltOn, 7'd0, TickDiv);
    expect_cycles("fault_tsv_off", PhFltOf, 7'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Traffic-light phase sequencer for a two-road intersection (principal and secondary roads), with a pedestrian head for each.
- Sits directly upstream of the LCD output stage. It drives that stage's phase, lamp, pedestrian, phrase-select and countdown inputs.
- Runs from the 50 MHz system clock and derives a 1-second tick internally.
- Phase durations (Tpv principal green, Tsv secondary green, Ta amber) come from configuration inputs in whole seconds.

Parameters:
- TICK_DIV, 50_000_000: clock50MHz cycles per 1-second tick. Legal range is 2 or more; benches use 4.

Ports:
- clock50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Tpv  in  7  principal green duration, seconds.
- Tsv  in  7  secondary green duration, seconds.
- Ta  in  7  amber duration, seconds.
- Principal_Road  out  3  lamp {R,Y,G}, one-hot.
- Secondary_Road  out  3  lamp {R,Y,G}, one-hot.
- Principal_Pedestrian  out  2  {STOP,WALK}, one-hot.
- Secondary_Pedestrian  out  2  {STOP,WALK}, one-hot.
- timeRemaining  out  7  seconds left in current phase, range 0..99.
- StateFlag  out  2  phase code: 0 = PG, 1 = PY, 2 = SG, 3 = SY.
- PhraseSel  out  2  display page: 0 = principal phases, 1 = secondary phases, 2 = all-red, 3 = fault.

Behaviour:
- All outputs are registered.
- Reset values (reset=0, asynchronous):
  - state = INIT, both roads 3'b100 (red), both pedestrian heads 2'b10 (stop).
  - timeRemaining = 0, StateFlag = 0, PhraseSel = 0, tick counter = 0.
- Tick generation:
  - Counter runs 0..TICK_DIV-1; tick pulses one cycle when the counter reaches TICK_DIV-1.
  - Counter is cleared on every phase entry, so the first tick lands exactly TICK_DIV cycles after entry.
- Duration validity: a duration is valid iff 1 ≤ value ≤ 99.
- Phase load:
  - On phase entry, the selected duration is sampled into timeRemaining.
  - If any of Tpv, Tsv, Ta is invalid at load time, go to FAULT instead.
  - Input changes mid-phase do not affect the running phase.
- INIT: on the first clock edge after reset release, load PG.
- Phase outputs:
  - PG: P road green, S road red. Secondary_Pedestrian WALK, Principal_Pedestrian STOP. StateFlag 0, PhraseSel 0. Duration Tpv.
  - PY: P road amber, S road red. Both pedestrian heads STOP. StateFlag 1, PhraseSel 0. Duration Ta.
  - SG: S road green, P road red. Principal_Pedestrian WALK, Secondary_Pedestrian STOP. StateFlag 2, PhraseSel 1. Duration Tsv.
  - SY: S road amber, P road red. Both pedestrian heads STOP. StateFlag 3, PhraseSel 1. Duration Ta.
- Countdown and sequencing:
  - On each tick, if timeRemaining > 1, decrement it.
  - If timeRemaining == 1, advance PG→PY→SG→SY→PG and load the next duration in the same cycle.
  - Each phase therefore shows N..1 for exactly N ticks.
- FAULT:
  - Outputs: both roads amber, toggling amber/off (3'b000) each tick, starting lit. Both pedestrian heads STOP. timeRemaining 0, StateFlag 0, PhraseSel 3.
  - Exit: on a tick where all three durations are valid, load PG.
- Reset asserted mid-phase: immediately return to reset values. Nothing is retained.
- Invariants:
  - Never both roads green or amber simultaneously, except FAULT flashing.
  - A WALK signal is never issued on a road whose vehicle lamp is not red.

Optional Feature:
- Macro: ALL_RED_CLEARANCE_EN.
- When defined:
  - An AR state is inserted after PY and after SY.
  - AR: both roads red, both pedestrian heads STOP, timeRemaining = 1, PhraseSel 2.
  - StateFlag holds the code of the preceding amber phase.
  - AR lasts exactly one tick, then loads SG (after PY) or PG (after SY) with the normal validity check.
- When not defined: amber advances directly to the opposing green; the AR state and PhraseSel 2 never appear.

Test Plan:
1. Reset release, TICK_DIV=4, Tpv=3, Tsv=2, Ta=1:
   - PG shows timeRemaining 3,2,1 over 12 cycles, then PY 1 for 4 cycles, SG 2,1, SY 1, back to PG 3.
   - Lamp and pedestrian codes match the Behaviour table at each phase.
2. Change Tpv 3→5 during PG:
   - Current PG still runs 3 ticks.
   - Next PG loads 5.
3. Ta=0 at reset release:
   - Enters FAULT: PhraseSel 3, roads alternate 3'b010 / 3'b000 every 4 cycles.
   - Set Ta=2 → next tick enters PG with timeRemaining = Tpv.
4. Tsv=100 when PY expires:
   - Enters FAULT, not SG.
5. Assert reset mid-SG:
   - All outputs return to reset values asynchronously, without waiting for a clock edge.
   - After release, sequence restarts at PG.
6. With ALL_RED_CLEARANCE_EN defined:
   - After PY: 4 cycles with both roads 3'b100, PhraseSel 2, StateFlag 1, then SG.
   - After SY: AR with StateFlag 3, then PG.
